simmem_axi_read_responder: RTL and testbench
============================================

// Module: simmem_axi_read_responder
// PURPOSE
// - AXI4 read responder (memory side) for the simmem delay model. Consumes raddr_t requests and returns rdata_t bursts.
// - Sits downstream of simmem; plays the real memory so the simulated-delay path can be closed in a self-contained bench.
// - Backing store is a small word array, loaded through a backdoor write port. Bursts of type FIXED, INCR and WRAP are supported.
// PARAMETERS
// - MemWords      64  Backing-store depth in words of MaxBurstSizeBytes bytes (power of 2).
// - ReqQueueDepth 4   Depth of the request queue (power of 2, >= 2).
// PORTS
// - clk_i         in   1                      Clock.
// - rst_i         in   1                      Reset: synchronous, active-high.
// - raddr_i       in   $bits(raddr_t)         Read address request.
// - raddr_valid_i in   1                      Request valid.
// - raddr_ready_o out  1                      Request accepted when valid & ready.
// - rdata_o       out  $bits(rdata_t)         Read beat: id, data, response, last.
// - rdata_valid_o out  1                      Beat valid.
// - rdata_ready_i in   1                      Beat consumed when valid & ready.
// - mem_we_i      in   1                      Backdoor write enable.
// - mem_waddr_i   in   $clog2(MemWords)       Backdoor word index.
// - mem_wdata_i   in   MaxBurstSizeBytes      Backdoor write data.
// BEHAVIOUR
// - Reset: queue empty; FSM in IDLE; rdata_valid_o=0; rdata_o=0; raddr_ready_o=0 while rst_i=1.
//   The memory array is not reset. Reset mid-burst drops the remaining beats.
// - raddr_ready_o = !queue_full (registered count). A request accepted in cycle N gives its first beat
//   with rdata_valid_o=1 no earlier than N+2.
// - FSM states:
//   - IDLE: if the queue is non-empty, pop the head, latch id/addr/len/size/type and error flag, emit the first beat, go to BURST.
//   - BURST: on each valid&ready, emit the next beat. On the last beat, if the queue is non-empty, pop and start the next burst
//     in the same cycle (no bubble); otherwise go to IDLE.
// - Beat count = burst_len+1. last=1 only on the final beat. id is copied to every beat.
// - Output is registered. While valid & !ready, rdata_o is held stable. With ready held high, throughput is 1 beat/cycle.
// - Addressing: bytes = 1<<burst_size. Word index = addr >> $clog2(MaxBurstSizeBytes).
//   - FIXED: addr constant.
//   - INCR: addr += bytes, modulo 2^AxAddrWidth.
//   - WRAP: boundary = addr & ~(bytes*(len+1)-1); addr wraps to boundary on reaching boundary+bytes*(len+1).
// - Error cases: burst marked SLVERR (response=RSP_SLVERR, data=0 on every affected beat), beat count unchanged, if any of:
//   - burst_len+1 > MaxRBurstLen
//   - bytes > MaxBurstSizeBytes
//   - burst_type=BURST_RESERVED
//   - WRAP with len not in {1,3,7}
// - Per-beat SLVERR: a beat whose word index >= MemWords gives SLVERR with data=0. Other beats of that burst stay OKAY.
// - OKAY beats: response=RSP_OKAY; data = mem[word] read in the cycle the beat is loaded.
//   A backdoor write to the same word in that cycle is not visible (read-before-write).
// - Simultaneous push and pop on a full queue: the pop frees a slot, but ready stays registered low that cycle (no bypass).
// CONFIGURATION
// - SIMMEM_RESPONDER_RANDOM_STALL_EN defined: an 8-bit Fibonacci LFSR (seed 8'hA5 on reset, taps 8,6,5,4) advances every cycle.
//   - raddr_ready_o = !queue_full & !lfsr[0].
//   - Emission of a new beat is held while lfsr[1]=1. rdata_o/valid stay stable.
// - Not defined: no LFSR; behaviour as above with no stalls.
// STRUCTURE
// - simmem_pkg additions:
//   - rsp_e enum (RSP_OKAY=0, RSP_EXOKAY=1, RSP_SLVERR=2, RSP_DECERR=3) in WStrbWidth bits.
//   - MaxBurstSizeW = $clog2(MaxBurstSizeBytes).
//   - raddr_t and rdata_t are reused unchanged.
// - Sub-module simmem_req_fifo: synchronous FIFO of raddr_t, ReqQueueDepth entries, registered full/empty.
//   The burst FSM, address generator and memory stay in this file.
// TESTING
// - Preload mem[i]=i[3:0]; INCR id=1 addr=0x0008 len=3 size=2 -> 4 beats with data 2,3,4,5, id=1, OKAY, last on beat 4.
// - WRAP addr=0x000C len=3 size=2 -> words 3,0,1,2. WRAP len=2 -> 3 beats, all SLVERR, data=0.
// - FIXED addr=0x0010 len=2 -> 3 beats, all word 4. INCR addr=0x00FC len=1 -> word 63 OKAY, word 64 SLVERR.
// - Two queued INCR len=0 requests, rdata_ready_i=1 -> beats in consecutive cycles. rdata_ready_i low for 3 cycles -> rdata_o stable.
// - Fill the queue with 4 requests while rdata_ready_i=0 -> raddr_ready_o=0. Assert rst_i mid-burst -> next cycle rdata_valid_o=0, queue empty.
// - len=8 (9 beats) -> 9 SLVERR beats. burst_type=3 -> SLVERR. Backdoor write to word 5 in the load cycle -> old value returned.

Source files
------------

// File: rtl/simmem_pkg.sv
// Shared types and constants for the simmem read responder.
// Contents:
//   - AXI field widths and the largest supported beat/burst shapes
//   - burst_type_e : FIXED / INCR / WRAP / RESERVED encodings of burst_type
//   - rsp_e        : AXI read response codes, WStrbWidth bits wide
//   - raddr_t      : read address request (id, addr, burst_len, burst_size, burst_type)
//   - rdata_t      : read beat (id, data, rsp, last)
//   - resp_fsm_e   : burst sequencer states (IDLE / BURST)
//   - burst_is_err : whole-burst legality check
//   - next_addr    : beat-to-beat address step for FIXED / INCR / WRAP
package simmem_pkg;

  localparam int unsigned IdWidth           = 4;
  localparam int unsigned AxAddrWidth       = 16;
  localparam int unsigned AxLenWidth        = 8;
  localparam int unsigned AxSizeWidth       = 3;
  localparam int unsigned AxBurstWidth      = 2;
  localparam int unsigned MaxBurstSizeBytes = 4;
  localparam int unsigned MaxBurstSizeW     = $clog2(MaxBurstSizeBytes);
  localparam int unsigned MaxRBurstLen      = 8;
  localparam int unsigned WStrbWidth        = MaxBurstSizeBytes;

  typedef logic [AxAddrWidth:0] addr_ext_t;

  typedef enum logic [AxBurstWidth-1:0] {
    BURST_FIXED    = 2'd0,
    BURST_INCR     = 2'd1,
    BURST_WRAP     = 2'd2,
    BURST_RESERVED = 2'd3
  } burst_type_e;

  typedef enum logic [WStrbWidth-1:0] {
    RSP_OKAY   = 4'd0,
    RSP_EXOKAY = 4'd1,
    RSP_SLVERR = 4'd2,
    RSP_DECERR = 4'd3
  } rsp_e;

  typedef struct packed {
    logic [IdWidth-1:0]      id;
    logic [AxAddrWidth-1:0]  addr;
    logic [AxLenWidth-1:0]   burst_len;
    logic [AxSizeWidth-1:0]  burst_size;
    logic [AxBurstWidth-1:0] burst_type;
  } raddr_t;

  typedef struct packed {
    logic [IdWidth-1:0]           id;
    logic [MaxBurstSizeBytes-1:0] data;
    rsp_e                         rsp;
    logic                         last;
  } rdata_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } resp_fsm_e;

  // A burst is rejected as a whole when its shape cannot be served.
  function automatic logic burst_is_err(input raddr_t r);
    logic len_too_long;
    logic size_too_big;
    logic wrap_len_bad;
    len_too_long = ({1'b0, r.burst_len} + 9'd1) > 9'(MaxRBurstLen);
    size_too_big = r.burst_size > AxSizeWidth'(MaxBurstSizeW);
    wrap_len_bad = (r.burst_type == BURST_WRAP) &&
                   !((r.burst_len == 8'd1) || (r.burst_len == 8'd3) || (r.burst_len == 8'd7));
    return len_too_long || size_too_big || (r.burst_type == BURST_RESERVED) || wrap_len_bad;
  endfunction

  // Address of the beat following 'addr'. The extra top bit keeps
  // boundary + span from overflowing at the top of the address space.
  function automatic logic [AxAddrWidth-1:0] next_addr(
    input logic [AxAddrWidth-1:0]  addr,
    input logic [AxSizeWidth-1:0]  size,
    input logic [AxLenWidth-1:0]   len,
    input logic [AxBurstWidth-1:0] btype
  );
    addr_ext_t bytes;
    addr_ext_t span;
    addr_ext_t boundary;
    addr_ext_t incr;
    bytes    = addr_ext_t'(1) << size;
    span     = bytes * (addr_ext_t'(len) + addr_ext_t'(1));
    boundary = addr_ext_t'(addr) & ~(span - addr_ext_t'(1));
    incr     = addr_ext_t'(addr) + bytes;
    case (btype)
      BURST_FIXED: return addr;
      BURST_WRAP: begin
        if (incr >= boundary + span) return AxAddrWidth'(incr - span);
        else                         return AxAddrWidth'(incr);
      end
      default: return AxAddrWidth'(incr);
    endcase
  endfunction

endpackage

// File: rtl/simmem_req_fifo.sv
// Request queue in front of the burst sequencer.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i         write wdata_i (caller guarantees !full_o)
//   wdata_i        raddr_t request
//   pop_i          drop the head entry (caller guarantees !empty_o)
//   rdata_o        head entry, valid while !empty_o
//   full_o         registered: Depth entries held
//   empty_o        registered: no entries held
module simmem_req_fifo
  import simmem_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  raddr_t wdata_i,
  input  logic   pop_i,
  output raddr_t rdata_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;

  raddr_t store_q [Depth];
  ptr_t   wptr_q;
  ptr_t   rptr_q;
  cnt_t   count_q;
  cnt_t   count_d;
  logic   full_q;
  logic   empty_q;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + cnt_t'(1);
    else if (!push_i && pop_i) count_d = count_q - cnt_t'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_i) wptr_q <= wptr_q + ptr_t'(1);
      if (pop_i)  rptr_q <= rptr_q + ptr_t'(1);
      count_q <= count_d;
      full_q  <= (count_d == cnt_t'(Depth));
      empty_q <= (count_d == '0);
    end
  end

  // Storage is not reset; the pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) store_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = store_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/simmem_axi_read_responder.sv
// AXI4 read responder playing the memory behind the simmem delay model.
// Requests are queued in simmem_req_fifo; a two-state sequencer expands
// each request into burst_len+1 registered beats read from a small word
// array that is loaded through a backdoor write port.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   raddr_i / raddr_valid_i / raddr_ready_o   request channel
//   rdata_o / rdata_valid_o / rdata_ready_i   beat channel
//   mem_we_i, mem_waddr_i, mem_wdata_i        backdoor word write
// Build option: SIMMEM_RESPONDER_RANDOM_STALL_EN adds LFSR-driven
// back-pressure on the request channel and gaps between beats.
//
// Handshake: on both channels a transfer happens on a rising edge where
// valid and ready are both high. A producer holding valid keeps its
// payload stable until that edge; ready may change freely.
module simmem_axi_read_responder
  import simmem_pkg::*;
#(
  parameter int unsigned MemWords      = 64,
  parameter int unsigned ReqQueueDepth = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  raddr_t                        raddr_i,
  input  logic                          raddr_valid_i,
  output logic                          raddr_ready_o,
  output rdata_t                        rdata_o,
  output logic                          rdata_valid_o,
  input  logic                          rdata_ready_i,
  input  logic                          mem_we_i,
  input  logic [$clog2(MemWords)-1:0]   mem_waddr_i,
  input  logic [MaxBurstSizeBytes-1:0]  mem_wdata_i
);

  localparam int unsigned MemAw = $clog2(MemWords);
  localparam int unsigned BeatW = AxLenWidth + 1;
  typedef logic [BeatW-1:0] beat_cnt_t;

  // ---------------- request queue ----------------
  raddr_t head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   push;
  logic   pop;
  logic   accept_gate;
  logic   stall;

  simmem_req_fifo #(.Depth(ReqQueueDepth)) u_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (raddr_i),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef SIMMEM_RESPONDER_RANDOM_STALL_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 8'hA5;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  assign accept_gate = !lfsr_q[0];
  assign stall       = lfsr_q[1];
`else
  assign accept_gate = 1'b1;
  assign stall       = 1'b0;
`endif

  // full is registered, so a pop in the same cycle does not reopen ready.
  assign raddr_ready_o = !fifo_full && accept_gate && !rst_i;
  assign push          = raddr_valid_i && raddr_ready_o;

  // ---------------- backing store ----------------
  logic [MaxBurstSizeBytes-1:0] mem [MemWords];

  always_ff @(posedge clk_i) begin
    if (mem_we_i) mem[mem_waddr_i] <= mem_wdata_i;
  end

  // ---------------- burst sequencer ----------------
  resp_fsm_e state_q, state_d;
  rdata_t    rdata_q, rdata_d;
  logic      valid_q, valid_d;
  beat_cnt_t beats_q, beats_d;   // beats of the current burst not yet emitted
  logic [IdWidth-1:0]      id_q, id_d;
  logic [AxAddrWidth-1:0]  addr_q, addr_d;
  logic [AxLenWidth-1:0]   len_q, len_d;
  logic [AxSizeWidth-1:0]  size_q, size_d;
  logic [AxBurstWidth-1:0] type_q, type_d;
  logic                    err_q, err_d;

  logic                    sel_new;
  logic                    have_work;
  logic                    out_free;
  logic                    emit;
  logic [IdWidth-1:0]      src_id;
  logic [AxAddrWidth-1:0]  src_addr;
  logic [AxLenWidth-1:0]   src_len;
  logic [AxSizeWidth-1:0]  src_size;
  logic [AxBurstWidth-1:0] src_type;
  logic                    src_err;
  beat_cnt_t               src_beats;
  logic [AxAddrWidth-1:0]  word;
  logic                    in_range;
  rdata_t                  beat;

  // Pick the beat source: the active burst if it still owes beats,
  // otherwise the queue head. Taking the head as soon as the final beat
  // is consumed is what removes the bubble between bursts.
  always_comb begin
    sel_new   = (state_q == ST_IDLE) || (beats_q == '0);
    src_id    = id_q;
    src_addr  = addr_q;
    src_len   = len_q;
    src_size  = size_q;
    src_type  = type_q;
    src_err   = err_q;
    src_beats = beats_q;
    have_work = 1'b1;
    if (sel_new) begin
      src_id    = head.id;
      src_addr  = head.addr;
      src_len   = head.burst_len;
      src_size  = head.burst_size;
      src_type  = head.burst_type;
      src_err   = burst_is_err(head);
      src_beats = beat_cnt_t'(head.burst_len) + beat_cnt_t'(1);
      have_work = !fifo_empty;
    end

    word     = src_addr >> MaxBurstSizeW;
    in_range = word < AxAddrWidth'(MemWords);

    beat      = '0;
    beat.id   = src_id;
    beat.last = (src_beats == beat_cnt_t'(1));
    if (src_err || !in_range) begin
      beat.rsp  = RSP_SLVERR;
      beat.data = '0;
    end else begin
      beat.rsp  = RSP_OKAY;
      beat.data = mem[word[MemAw-1:0]];
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    beats_d = beats_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    type_d  = type_q;
    err_d   = err_q;

    out_free = !valid_q || rdata_ready_i;
    emit     = out_free && !stall && have_work;
    pop      = emit && sel_new;

    if (emit) begin
      state_d = ST_BURST;
      rdata_d = beat;
      valid_d = 1'b1;
      beats_d = src_beats - beat_cnt_t'(1);
      id_d    = src_id;
      addr_d  = next_addr(src_addr, src_size, src_len, src_type);
      len_d   = src_len;
      size_d  = src_size;
      type_d  = src_type;
      err_d   = src_err;
    end else begin
      // Beat consumed with nothing new to load: drop valid, keep data.
      if (valid_q && rdata_ready_i) valid_d = 1'b0;
      if (!have_work && !valid_d)   state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      valid_q <= 1'b0;
      beats_q <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      type_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      beats_q <= beats_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      type_q  <= type_d;
      err_q   <= err_d;
    end
  end

  assign rdata_o       = rdata_q;
  assign rdata_valid_o = valid_q;

endmodule

// File: tb/tb_simmem_axi_read_responder.sv
// Bench for simmem_axi_read_responder: directed bursts from the block's
// own examples, queue/reset corner cases, then randomized traffic, all
// checked against a behavioural model of the burst rules.
`timescale 1ns/1ps
module tb_simmem_axi_read_responder;
  import simmem_pkg::*;

  localparam int MemWords = 64;
  localparam int MemAw    = 6;
  localparam int Depth    = 4;
  localparam int RW       = $bits(rdata_t);

  // ---------------- clock / reset / DUT ----------------
  logic                         clk = 1'b0;
  logic                         rst_i;
  raddr_t                       raddr_i;
  logic                         raddr_valid_i;
  logic                         raddr_ready_o;
  rdata_t                       rdata_o;
  logic                         rdata_valid_o;
  logic                         rdata_ready_i;
  logic                         mem_we_i;
  logic [MemAw-1:0]             mem_waddr_i;
  logic [MaxBurstSizeBytes-1:0] mem_wdata_i;

  always #5 clk = ~clk;

  simmem_axi_read_responder #(.MemWords(MemWords), .ReqQueueDepth(Depth)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .raddr_i       (raddr_i),
    .raddr_valid_i (raddr_valid_i),
    .raddr_ready_o (raddr_ready_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .rdata_ready_i (rdata_ready_i),
    .mem_we_i      (mem_we_i),
    .mem_waddr_i   (mem_waddr_i),
    .mem_wdata_i   (mem_wdata_i)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int beats_seen = 0;
  logic [RW-1:0] exp_q[$];
  logic [MaxBurstSizeBytes-1:0] mem_model [MemWords];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expands one accepted request into its expected beats using plain
  // arithmetic: linear, modular-window or constant addressing.
  task automatic model_push(input raddr_t r);
    int bytes, n, span, base, a, word, bt, addr;
    bit err;
    rdata_t b;
    bytes = 1 << r.burst_size;
    n     = int'(r.burst_len) + 1;
    bt    = int'(r.burst_type);
    addr  = int'(r.addr);
    span  = bytes * n;
    base  = (addr / span) * span;
    err   = (n > 8) || (bytes > 4) || (bt == 3) || (bt == 2 && n != 2 && n != 4 && n != 8);
    for (int k = 0; k < n; k++) begin
      if (bt == 0)      a = addr;
      else if (bt == 2) a = base + ((addr - base) + k * bytes) % span;
      else              a = (addr + k * bytes) % 65536;
      word   = a / 4;
      b      = '0;
      b.id   = r.id;
      b.last = (k == n - 1);
      if (err || word >= MemWords) begin
        b.rsp  = RSP_SLVERR;
        b.data = '0;
      end else begin
        b.rsp  = RSP_OKAY;
        b.data = mem_model[word];
      end
      exp_q.push_back(b);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst_i) begin
      exp_q.delete();
    end else begin
      if (raddr_valid_i && raddr_ready_o) model_push(raddr_i);
      if (rdata_valid_o && rdata_ready_i) begin
        if (exp_q.size() == 0) check("unexpected_beat", rdata_o, '1);
        else begin
          check("beat", rdata_o, exp_q.pop_front());
          beats_seen++;
        end
      end else if (rdata_valid_o) begin
        if (exp_q.size() == 0) check("hold_unexpected", rdata_o, '1);
        else                   check("hold", rdata_o, exp_q[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic raddr_t mk(input int id, input int addr, input int len, input int size, input int btype);
    raddr_t r;
    r.id         = IdWidth'(id);
    r.addr       = AxAddrWidth'(addr);
    r.burst_len  = AxLenWidth'(len);
    r.burst_size = AxSizeWidth'(size);
    r.burst_type = AxBurstWidth'(btype);
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic send_req(input raddr_t r);
    int guard;
    guard = 0;
    raddr_i       = r;
    raddr_valid_i = 1'b1;
    @(negedge clk);
    while (!raddr_ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("req_timeout", 64'(guard), 64'(0));
    @(posedge clk); #1;
    raddr_valid_i = 1'b0;
  endtask

  task automatic mem_write(input int idx, input int val);
    mem_we_i    = 1'b1;
    mem_waddr_i = MemAw'(idx);
    mem_wdata_i = MaxBurstSizeBytes'(val);
    mem_model[idx] = MaxBurstSizeBytes'(val);
    @(posedge clk); #1;
    mem_we_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || rdata_valid_o) && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    check({tag, "_drain"}, 64'(guard < 3000), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic run_burst(input string tag, input raddr_t r, input int nbeats);
    int b0;
    b0 = beats_seen;
    send_req(r);
    wait_drain(tag);
    check({tag, "_beats"}, 64'(beats_seen - b0), 64'(nbeats));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    raddr_t r;
    int acc;
    int b0;
    bit done;

    rst_i         = 1'b1;
    raddr_i       = '0;
    raddr_valid_i = 1'b0;
    rdata_ready_i = 1'b1;
    mem_we_i      = 1'b0;
    mem_waddr_i   = '0;
    mem_wdata_i   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(rdata_valid_o), 64'(0));
    check("rst_data",  64'(rdata_o), 64'(0));
    check("rst_ready", 64'(raddr_ready_o), 64'(0));
    @(posedge clk); #1;
    rst_i = 1'b0;

    for (int i = 0; i < MemWords; i++) mem_write(i, i & 15);
    @(negedge clk);
    check("ready_idle", 64'(raddr_ready_o), 64'(1));
    @(posedge clk); #1;

    // First beat of a request accepted in cycle N must not appear in N+1.
    b0 = beats_seen;
    send_req(mk(1, 'h0008, 3, 2, 1));
    @(negedge clk);
    check("latency_n1", 64'(rdata_valid_o), 64'(0));
    @(posedge clk); #1;
    wait_drain("incr");
    check("incr_beats", 64'(beats_seen - b0), 64'(4));

    run_burst("wrap4",      mk(2, 'h000C, 3, 2, 2), 4);
    run_burst("wrap_len2",  mk(3, 'h0000, 2, 2, 2), 3);
    run_burst("fixed",      mk(4, 'h0010, 2, 2, 0), 3);
    run_burst("edge_word",  mk(5, 'h00FC, 1, 2, 1), 2);
    run_burst("len8_err",   mk(6, 'h0000, 8, 2, 1), 9);
    run_burst("rsvd_type",  mk(7, 'h0000, 1, 2, 3), 2);
    run_burst("size3_err",  mk(8, 'h0000, 1, 3, 1), 2);

    // Two single-beat bursts drain on consecutive cycles.
    rdata_ready_i = 1'b0;
    send_req(mk(10, 'h0000, 0, 2, 1));
    send_req(mk(11, 'h0004, 0, 2, 1));
    repeat (2) @(posedge clk);
    #1;
    rdata_ready_i = 1'b1;
    @(negedge clk);
    check("b2b_first", 64'(rdata_valid_o), 64'(1));
    @(negedge clk);
    check("b2b_second", 64'(rdata_valid_o), 64'(1));
    @(negedge clk);
    check("b2b_after", 64'(rdata_valid_o), 64'(0));
    @(posedge clk); #1;

    // Back-pressure: beat held stable (monitor checks it each cycle).
    rdata_ready_i = 1'b0;
    send_req(mk(12, 'h0020, 3, 2, 1));
    repeat (4) @(posedge clk);
    #1;
    check("stall_valid", 64'(rdata_valid_o), 64'(1));
    rdata_ready_i = 1'b1;
    wait_drain("stall");

    // Backdoor write in the load cycle is not visible; a later read sees it.
    send_req(mk(13, 'h0014, 0, 2, 1));
    mem_write(5, 'hA);
    wait_drain("rbw_old");
    run_burst("rbw_new", mk(14, 'h0014, 0, 2, 1), 1);

    // Fill: one request moves into the output register, Depth fill the queue.
    rdata_ready_i = 1'b0;
    raddr_i       = mk(15, 'h0040, 1, 2, 1);
    raddr_valid_i = 1'b1;
    acc = 0;
    repeat (12) begin
      @(negedge clk);
      if (raddr_ready_o) acc++;
    end
    check("fill_ready", 64'(raddr_ready_o), 64'(0));
    check("fill_count", 64'(acc), 64'(Depth + 1));
    @(posedge clk); #1;
    raddr_valid_i = 1'b0;

    // Reset mid-burst: consume a few beats, then reset.
    rdata_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", 64'(raddr_ready_o), 64'(0));
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 64'(rdata_valid_o), 64'(0));
    check("rst_mid_data",  64'(rdata_o), 64'(0));
    check("rst_mid_rdy",   64'(raddr_ready_o), 64'(1));
    repeat (4) begin
      @(negedge clk);
      check("rst_q_empty", 64'(rdata_valid_o), 64'(0));
    end
    @(posedge clk); #1;

    // Randomized traffic with random consumer back-pressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          int sz, bt, ln, ad;
          sz = $urandom_range(0, 3);
          bt = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
          if (bt == 2 && $urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 2))
              0:       ln = 1;
              1:       ln = 3;
              default: ln = 7;
            endcase
          end else begin
            ln = $urandom_range(0, 9);
          end
          ad = ($urandom_range(0, 9) == 0) ? $urandom_range('hFF00, 'hFFFF) : $urandom_range(0, 280);
          ad = ad & ~((1 << sz) - 1);
          r  = mk($urandom_range(0, 15), ad, ln, sz, bt);
          send_req(r);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          rdata_ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rdata_ready_i = 1'b1;
    wait_drain("random");
    check("final_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
